// File: rtl/femtorv32_pkg.sv
// Shared definitions for the femtorv32 RV32I core: opcodes, funct3 codes,
// FSM states and the load-lane extraction helper.
package femtorv32_pkg;

   localparam logic [31:0] RESET_ADDR = 32'h0000_0000;
   localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_OP     = 7'b0110011;

   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_SLL  = 3'b001;
   localparam logic [2:0] F3_SLT  = 3'b010;
   localparam logic [2:0] F3_SLTU = 3'b011;
   localparam logic [2:0] F3_XOR  = 3'b100;
   localparam logic [2:0] F3_SR   = 3'b101;
   localparam logic [2:0] F3_OR   = 3'b110;
   localparam logic [2:0] F3_AND  = 3'b111;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   typedef enum logic [1:0] {
      FETCH_INSTR = 2'd0,
      WAIT_INSTR  = 2'd1,
      EXECUTE     = 2'd2,
      WAIT_MEM    = 2'd3
   } state_e;

   // funct3[1:0] selects size, funct3[2] selects zero-extension
   function automatic logic [31:0] load_extract(input logic [31:0] rdata,
                                                input logic [1:0]  lo,
                                                input logic [2:0]  f3);
      logic [7:0]  byte_v;
      logic [15:0] half_v;
      logic [31:0] res_v;
      case (lo)
         2'd0:    byte_v = rdata[7:0];
         2'd1:    byte_v = rdata[15:8];
         2'd2:    byte_v = rdata[23:16];
         default: byte_v = rdata[31:24];
      endcase
      half_v = lo[1] ? rdata[31:16] : rdata[15:0];
      case (f3[1:0])
         2'b00:   res_v = {{24{byte_v[7] & ~f3[2]}}, byte_v};
         2'b01:   res_v = {{16{half_v[15] & ~f3[2]}}, half_v};
         default: res_v = rdata;
      endcase
      return res_v;
   endfunction

endpackage

// File: rtl/femtorv32_if.sv
// Memory bus and instruction-progress pulses between the core and its memory.
interface femtorv32_if;
   logic [31:0] mem_addr;
   logic [31:0] mem_rdata;
   logic        mem_rstrb;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wmask;
   logic        inst_start;
   logic        inst_done;

   modport master (
      output mem_addr, mem_rstrb, mem_wdata, mem_wmask, inst_start, inst_done,
      input  mem_rdata
   );

   modport slave (
      input  mem_addr, mem_rstrb, mem_wdata, mem_wmask, inst_start, inst_done,
      output mem_rdata
   );
endinterface

// File: rtl/femtorv32_alu.sv
// Combinational RV32I ALU with single-cycle barrel shifter and branch compare.
module femtorv32_alu
   import femtorv32_pkg::*;
(
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [2:0]  funct3,
   input  logic        alt,
   output logic [31:0] result,
   output logic        br_taken
);
   logic [31:0] sum_s;
   logic [4:0]  shamt_s;
   logic        eq_s;
   logic        lt_s;
   logic        ltu_s;

   assign sum_s   = alt ? (a - b) : (a + b);
   assign shamt_s = b[4:0];
   assign eq_s    = (a == b);
   assign lt_s    = ($signed(a) < $signed(b));
   assign ltu_s   = (a < b);

   // arithmetic/logic result selected by funct3
   always_comb begin
      result = 32'h0000_0000;
      case (funct3)
         F3_ADD:  result = sum_s;
         F3_SLL:  result = a << shamt_s;
         F3_SLT:  result = {31'h0000_0000, lt_s};
         F3_SLTU: result = {31'h0000_0000, ltu_s};
         F3_XOR:  result = a ^ b;
         F3_SR: begin
            if (alt) begin
               result = $unsigned($signed(a) >>> shamt_s);
            end else begin
               result = a >> shamt_s;
            end
         end
         F3_OR:   result = a | b;
         F3_AND:  result = a & b;
         default: result = 32'h0000_0000;
      endcase
   end

   // branch condition selected by funct3
   always_comb begin
      br_taken = 1'b0;
      case (funct3)
         F3_BEQ:  br_taken = eq_s;
         F3_BNE:  br_taken = ~eq_s;
         F3_BLT:  br_taken = lt_s;
         F3_BGE:  br_taken = ~lt_s;
         F3_BLTU: br_taken = ltu_s;
         F3_BGEU: br_taken = ~ltu_s;
         default: br_taken = 1'b0;
      endcase
   end
endmodule

// File: rtl/femtorv32.sv
// femtorv32: minimal multi-cycle RV32I core, 3 cycles per instruction,
// 4 per load. Bus outputs are decoded from registered state and gated by reset.
module femtorv32
   import femtorv32_pkg::*;
(
   input  logic        ft_clk,
   input  logic        resetn,
   femtorv32_if.master bus
);
   state_e      state_r;
   logic [31:0] PC;
   logic [31:0] instr_r;
   logic [31:0] RegisterBank [0:31];

   logic [6:0]  opcode_s;
   logic [4:0]  rd_s;
   logic [4:0]  rs1_idx_s;
   logic [4:0]  rs2_idx_s;
   logic [2:0]  funct3_s;
   logic [31:0] imm_i_s;
   logic [31:0] imm_s_s;
   logic [31:0] imm_b_s;
   logic [31:0] imm_u_s;
   logic [31:0] imm_j_s;
   logic [31:0] rs1_s;
   logic [31:0] rs2_s;
   logic [31:0] alu_b_s;
   logic        alt_s;
   logic [31:0] alu_out_s;
   logic        br_taken_s;
   logic [31:0] ls_addr_s;
   logic [31:0] pc_plus4_s;
   logic [31:0] next_pc_s;
   logic        exec_we_s;
   logic [31:0] exec_wd_s;
   logic [3:0]  st_mask_s;
   logic [31:0] st_data_s;
   logic        rf_we_s;
   logic [31:0] rf_wd_s;

   assign opcode_s  = instr_r[6:0];
   assign rd_s      = instr_r[11:7];
   assign funct3_s  = instr_r[14:12];
   assign rs1_idx_s = instr_r[19:15];
   assign rs2_idx_s = instr_r[24:20];
   assign imm_i_s   = {{20{instr_r[31]}}, instr_r[31:20]};
   assign imm_s_s   = {{20{instr_r[31]}}, instr_r[31:25], instr_r[11:7]};
   assign imm_b_s   = {{19{instr_r[31]}}, instr_r[31], instr_r[7], instr_r[30:25], instr_r[11:8], 1'b0};
   assign imm_u_s   = {instr_r[31:12], 12'h000};
   assign imm_j_s   = {{11{instr_r[31]}}, instr_r[31], instr_r[19:12], instr_r[20], instr_r[30:21], 1'b0};

   assign rs1_s = (rs1_idx_s == 5'd0) ? 32'h0000_0000 : RegisterBank[rs1_idx_s];
   assign rs2_s = (rs2_idx_s == 5'd0) ? 32'h0000_0000 : RegisterBank[rs2_idx_s];

   // bit 30 means SUB/SRA for register ops, but only SRAI among immediate ops
   assign alt_s   = (opcode_s == OP_OP) ? instr_r[30]
                  : ((opcode_s == OP_IMM) && (funct3_s == F3_SR)) ? instr_r[30] : 1'b0;
   assign alu_b_s = ((opcode_s == OP_OP) || (opcode_s == OP_BRANCH)) ? rs2_s : imm_i_s;

   femtorv32_alu u_alu (
      .a        (rs1_s),
      .b        (alu_b_s),
      .funct3   (funct3_s),
      .alt      (alt_s),
      .result   (alu_out_s),
      .br_taken (br_taken_s)
   );

   assign ls_addr_s  = rs1_s + ((opcode_s == OP_STORE) ? imm_s_s : imm_i_s);
   assign pc_plus4_s = PC + 32'd4;

   // writeback value and next PC for the EXECUTE cycle
   always_comb begin
      exec_we_s = 1'b0;
      exec_wd_s = 32'h0000_0000;
      next_pc_s = pc_plus4_s;
      case (opcode_s)
         OP_LUI: begin
            exec_we_s = 1'b1;
            exec_wd_s = imm_u_s;
         end
         OP_AUIPC: begin
            exec_we_s = 1'b1;
            exec_wd_s = PC + imm_u_s;
         end
         OP_JAL: begin
            exec_we_s = 1'b1;
            exec_wd_s = pc_plus4_s;
            next_pc_s = PC + imm_j_s;
         end
         OP_JALR: begin
            exec_we_s = 1'b1;
            exec_wd_s = pc_plus4_s;
            next_pc_s = (rs1_s + imm_i_s) & 32'hFFFF_FFFE;
         end
         OP_BRANCH: begin
            if (br_taken_s) begin
               next_pc_s = PC + imm_b_s;
            end else begin
               next_pc_s = pc_plus4_s;
            end
         end
         OP_IMM, OP_OP: begin
            exec_we_s = 1'b1;
            exec_wd_s = alu_out_s;
         end
         default: begin
            exec_we_s = 1'b0;
         end
      endcase
   end

   // store lane enables and lane-replicated data
   always_comb begin
      st_mask_s = 4'b0000;
      st_data_s = rs2_s;
      case (funct3_s[1:0])
         2'b00: begin
            st_mask_s = 4'b0001 << ls_addr_s[1:0];
            st_data_s = {4{rs2_s[7:0]}};
         end
         2'b01: begin
            st_mask_s = ls_addr_s[1] ? 4'b1100 : 4'b0011;
            st_data_s = {2{rs2_s[15:0]}};
         end
         default: begin
            st_mask_s = 4'b1111;
            st_data_s = rs2_s;
         end
      endcase
   end

   assign rf_we_s = resetn && (rd_s != 5'd0) &&
                    (((state_r == EXECUTE) && exec_we_s) || (state_r == WAIT_MEM));
   assign rf_wd_s = (state_r == WAIT_MEM) ? load_extract(bus.mem_rdata, ls_addr_s[1:0], funct3_s)
                                          : exec_wd_s;

   assign bus.mem_addr   = (state_r == FETCH_INSTR) ? PC : ls_addr_s;
   assign bus.mem_rstrb  = resetn && ((state_r == FETCH_INSTR) ||
                                      ((state_r == EXECUTE) && (opcode_s == OP_LOAD)));
   assign bus.mem_wmask  = (resetn && (state_r == EXECUTE) && (opcode_s == OP_STORE)) ? st_mask_s : 4'b0000;
   assign bus.mem_wdata  = st_data_s;
   assign bus.inst_start = resetn && (state_r == FETCH_INSTR);
   assign bus.inst_done  = resetn && (((state_r == EXECUTE) && (opcode_s != OP_LOAD)) ||
                                      (state_r == WAIT_MEM));

   // register file: x0 forced to zero, other registers keep their value through reset
   always_ff @(posedge ft_clk) begin
      RegisterBank[0] <= 32'h0000_0000;
      if (rf_we_s) begin
         RegisterBank[rd_s] <= rf_wd_s;
      end
   end

   // instruction sequencing FSM
   always_ff @(posedge ft_clk) begin
      if (!resetn) begin
         state_r <= FETCH_INSTR;
         PC      <= RESET_ADDR;
         instr_r <= NOP_INSTR;
      end else begin
         case (state_r)
            FETCH_INSTR: state_r <= WAIT_INSTR;
            WAIT_INSTR: begin
               instr_r <= bus.mem_rdata;
               state_r <= EXECUTE;
            end
            EXECUTE: begin
               if (opcode_s == OP_LOAD) begin
                  state_r <= WAIT_MEM;
               end else begin
                  PC      <= next_pc_s;
                  state_r <= FETCH_INSTR;
               end
            end
            WAIT_MEM: begin
               PC      <= pc_plus4_s;
               state_r <= FETCH_INSTR;
            end
            default: state_r <= FETCH_INSTR;
         endcase
      end
   end
endmodule

// File: tb/tb_femtorv32.sv
// Directed self-checking bench for femtorv32 with a behavioural word memory.
module tb_femtorv32;
   localparam logic [6:0] OPC_IMM   = 7'b0010011;
   localparam logic [6:0] OPC_OP    = 7'b0110011;
   localparam logic [6:0] OPC_LUI   = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC = 7'b0010111;
   localparam logic [6:0] OPC_LOAD  = 7'b0000011;
   localparam logic [6:0] OPC_JALR  = 7'b1100111;

   logic        ft_clk;
   logic        resetn;
   logic [31:0] mem [0:255];
   int          checks;
   int          errors;
   int          st_cnt;
   int          st_base;
   logic [3:0]  st_mask;
   logic [31:0] st_addr;
   logic [31:0] st_data;

   femtorv32_if bus_if ();

   femtorv32 dut (
      .ft_clk (ft_clk),
      .resetn (resetn),
      .bus    (bus_if)
   );

   initial ft_clk = 1'b0;
   always #5 ft_clk = ~ft_clk;

   // memory: read data one cycle after strobe, byte-lane writes
   always @(posedge ft_clk) begin
      if (bus_if.mem_rstrb) bus_if.mem_rdata <= mem[bus_if.mem_addr[9:2]];
      for (int k = 0; k < 4; k++) begin
         if (bus_if.mem_wmask[k]) mem[bus_if.mem_addr[9:2]][8*k +: 8] <= bus_if.mem_wdata[8*k +: 8];
      end
   end

   initial st_cnt = 0;
   always @(negedge ft_clk) begin
      if (bus_if.mem_wmask != 4'b0000) begin
         st_cnt  <= st_cnt + 1;
         st_mask <= bus_if.mem_wmask;
         st_addr <= bus_if.mem_addr;
         st_data <= bus_if.mem_wdata;
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3, input int rd, input logic [6:0] op);
      logic [31:0] t;
      t = imm;
      return {t[11:0], rs1[4:0], f3[2:0], rd[4:0], op};
   endfunction

   function automatic logic [31:0] enc_r(input int f7, input int rs2, input int rs1, input int f3, input int rd);
      return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], OPC_OP};
   endfunction

   function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1, input int f3);
      logic [31:0] t;
      t = imm;
      return {t[11:5], rs2[4:0], rs1[4:0], f3[2:0], t[4:0], 7'b0100011};
   endfunction

   function automatic logic [31:0] enc_b(input int imm, input int rs2, input int rs1, input int f3);
      logic [31:0] t;
      t = imm;
      return {t[12], t[10:5], rs2[4:0], rs1[4:0], f3[2:0], t[4:1], t[11], 7'b1100011};
   endfunction

   function automatic logic [31:0] enc_u(input int imm20, input int rd, input logic [6:0] op);
      logic [31:0] t;
      t = imm20;
      return {t[19:0], rd[4:0], op};
   endfunction

   function automatic logic [31:0] enc_j(input int imm, input int rd);
      logic [31:0] t;
      t = imm;
      return {t[20], t[10:1], t[11], t[19:12], rd[4:0], 7'b1101111};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic put(input int addr, input logic [31:0] w);
      mem[addr/4] <= w;
   endtask

   task automatic clear_mem();
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0000_0013;
   endtask

   // hold reset, check quiescent outputs, release and check first fetch
   task automatic do_reset(input string tag);
      resetn = 1'b0;
      repeat (3) @(negedge ft_clk);
      chk({tag, "_rst_start"}, {31'h0, bus_if.inst_start}, 32'h0);
      chk({tag, "_rst_done"},  {31'h0, bus_if.inst_done},  32'h0);
      chk({tag, "_rst_rstrb"}, {31'h0, bus_if.mem_rstrb},  32'h0);
      chk({tag, "_rst_wmask"}, {28'h0, bus_if.mem_wmask},  32'h0);
      chk({tag, "_rst_pc"},    dut.PC,                     32'h0);
      resetn = 1'b1;
      #1;
      chk({tag, "_fetch_start"}, {31'h0, bus_if.inst_start}, 32'h1);
      chk({tag, "_fetch_addr"},  bus_if.mem_addr,            32'h0);
   endtask

   // from a FETCH cycle, run one instruction and land on the next FETCH
   task automatic run_instr(input string tag, input int exp_cycles);
      int n;
      n = 1;
      chk({tag, "_start"}, {31'h0, bus_if.inst_start}, 32'h1);
      while (bus_if.inst_done !== 1'b1 && n < 12) begin
         @(negedge ft_clk);
         n++;
      end
      chk({tag, "_latency"}, n, exp_cycles);
      @(negedge ft_clk);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      resetn = 1'b0;

      // arithmetic, shifts, compares, x0
      clear_mem();
      put(32'h00, enc_i(5, 0, 0, 1, OPC_IMM));
      put(32'h04, enc_i(7, 0, 0, 1, OPC_IMM));
      put(32'h08, enc_i(3, 0, 0, 2, OPC_IMM));
      put(32'h0C, enc_r(32, 2, 1, 0, 3));
      put(32'h10, enc_u(32'h80000, 5, OPC_LUI));
      put(32'h14, enc_i(4, 0, 0, 8, OPC_IMM));
      put(32'h18, enc_r(32, 8, 5, 5, 4));
      put(32'h1C, enc_i(9, 0, 0, 0, OPC_IMM));
      put(32'h20, enc_i(-1, 0, 0, 12, OPC_IMM));
      put(32'h24, enc_r(0, 1, 5, 2, 10));
      put(32'h28, enc_r(0, 1, 5, 3, 11));
      put(32'h2C, enc_i(32'h41F, 5, 5, 9, OPC_IMM));
      put(32'h30, enc_i(4, 5, 5, 13, OPC_IMM));
      do_reset("a");
      run_instr("addi_x1", 3);
      chk("addi_x1_val", dut.RegisterBank[1], 32'h0000_0005);
      chk("addi_pc", dut.PC, 32'h0000_0004);
      run_instr("addi7", 3);
      run_instr("addi3", 3);
      run_instr("sub", 3);
      chk("sub_x3", dut.RegisterBank[3], 32'h0000_0004);
      run_instr("lui", 3);
      chk("lui_x5", dut.RegisterBank[5], 32'h8000_0000);
      run_instr("addi4", 3);
      run_instr("sra", 3);
      chk("sra_x4", dut.RegisterBank[4], 32'hF800_0000);
      run_instr("x0", 3);
      chk("x0_zero", dut.RegisterBank[0], 32'h0000_0000);
      run_instr("addi_neg", 3);
      chk("addi_neg_x12", dut.RegisterBank[12], 32'hFFFF_FFFF);
      run_instr("slt", 3);
      chk("slt_x10", dut.RegisterBank[10], 32'h0000_0001);
      run_instr("sltu", 3);
      chk("sltu_x11", dut.RegisterBank[11], 32'h0000_0000);
      run_instr("srai", 3);
      chk("srai_x9", dut.RegisterBank[9], 32'hFFFF_FFFF);
      run_instr("srli", 3);
      chk("srli_x13", dut.RegisterBank[13], 32'h0800_0000);
      chk("a_pc_end", dut.PC, 32'h0000_0034);

      // loads and stores
      resetn = 1'b0;
      clear_mem();
      put(32'h00, enc_u(32'h11223, 1, OPC_LUI));
      put(32'h04, enc_i(32'h344, 1, 0, 1, OPC_IMM));
      put(32'h08, enc_s(32'h40, 1, 0, 2));
      put(32'h0C, enc_i(32'h43, 0, 0, 6, OPC_LOAD));
      put(32'h10, enc_i(32'h43, 0, 4, 7, OPC_LOAD));
      put(32'h14, enc_u(32'h00008, 2, OPC_LUI));
      put(32'h18, enc_s(32'h42, 2, 0, 1));
      put(32'h1C, enc_i(32'h42, 0, 1, 8, OPC_LOAD));
      put(32'h20, enc_i(32'h42, 0, 5, 9, OPC_LOAD));
      put(32'h24, enc_s(32'h41, 1, 0, 0));
      put(32'h28, enc_i(32'h40, 0, 2, 10, OPC_LOAD));
      put(32'h2C, enc_i(32'h43, 0, 0, 11, OPC_LOAD));
      do_reset("b");
      run_instr("b_lui", 3);
      run_instr("b_addi", 3);
      chk("b_x1", dut.RegisterBank[1], 32'h1122_3344);
      st_base = st_cnt;
      run_instr("sw", 3);
      chk("sw_count", st_cnt - st_base, 32'd1);
      chk("sw_mask", {28'h0, st_mask}, 32'h0000_000F);
      chk("sw_addr", st_addr, 32'h0000_0040);
      chk("sw_data", st_data, 32'h1122_3344);
      run_instr("lb", 4);
      chk("lb_x6", dut.RegisterBank[6], 32'h0000_0011);
      run_instr("lbu", 4);
      chk("lbu_x7", dut.RegisterBank[7], 32'h0000_0011);
      run_instr("b_lui2", 3);
      st_base = st_cnt;
      run_instr("sh", 3);
      chk("sh_count", st_cnt - st_base, 32'd1);
      chk("sh_mask", {28'h0, st_mask}, 32'h0000_000C);
      chk("sh_data", st_data, 32'h8000_8000);
      run_instr("lh", 4);
      chk("lh_x8", dut.RegisterBank[8], 32'hFFFF_8000);
      run_instr("lhu", 4);
      chk("lhu_x9", dut.RegisterBank[9], 32'h0000_8000);
      st_base = st_cnt;
      run_instr("sb", 3);
      chk("sb_count", st_cnt - st_base, 32'd1);
      chk("sb_mask", {28'h0, st_mask}, 32'h0000_0002);
      chk("sb_data", st_data, 32'h4444_4444);
      chk("mem_word", mem[16], 32'h8000_4444);
      run_instr("lw", 4);
      chk("lw_x10", dut.RegisterBank[10], 32'h8000_4444);
      run_instr("lb_neg", 4);
      chk("lb_neg_x11", dut.RegisterBank[11], 32'hFFFF_FF80);
      chk("b_pc_end", dut.PC, 32'h0000_0030);

      // control flow and NOP-class opcodes
      resetn = 1'b0;
      clear_mem();
      put(32'h00, enc_i(32'h21, 0, 0, 2, OPC_IMM));
      put(32'h04, enc_j(12, 5));
      put(32'h08, enc_i(1, 0, 0, 7, OPC_IMM));
      put(32'h0C, enc_i(0, 2, 0, 1, OPC_JALR));
      put(32'h10, enc_b(-8, 0, 0, 0));
      put(32'h20, enc_b(8, 0, 0, 1));
      put(32'h24, enc_i(-1, 0, 0, 3, OPC_IMM));
      put(32'h28, enc_b(8, 0, 3, 4));
      put(32'h2C, enc_i(5, 0, 0, 3, OPC_IMM));
      put(32'h30, enc_b(8, 0, 3, 6));
      put(32'h34, enc_u(1, 4, OPC_AUIPC));
      put(32'h38, 32'h0000_000F);
      put(32'h3C, 32'h0000_0073);
      do_reset("c");
      run_instr("c_addi", 3);
      run_instr("jal", 3);
      chk("jal_pc", dut.PC, 32'h0000_0010);
      chk("jal_x5", dut.RegisterBank[5], 32'h0000_0008);
      run_instr("beq", 3);
      chk("beq_pc", dut.PC, 32'h0000_0008);
      run_instr("c_addi7", 3);
      run_instr("jalr", 3);
      chk("jalr_pc", dut.PC, 32'h0000_0020);
      chk("jalr_x1", dut.RegisterBank[1], 32'h0000_0010);
      run_instr("bne", 3);
      chk("bne_pc", dut.PC, 32'h0000_0024);
      run_instr("c_neg", 3);
      run_instr("blt", 3);
      chk("blt_pc", dut.PC, 32'h0000_0030);
      run_instr("bltu", 3);
      chk("bltu_pc", dut.PC, 32'h0000_0034);
      run_instr("auipc", 3);
      chk("auipc_x4", dut.RegisterBank[4], 32'h0000_1034);
      chk("c_x3", dut.RegisterBank[3], 32'hFFFF_FFFF);
      run_instr("fence", 3);
      run_instr("ecall", 3);
      chk("nop_pc", dut.PC, 32'h0000_0040);

      // reset during WAIT_MEM
      resetn = 1'b0;
      clear_mem();
      put(32'h00, enc_i(32'h55, 0, 0, 6, OPC_IMM));
      put(32'h04, enc_i(32'h40, 0, 2, 6, OPC_LOAD));
      put(32'h40, 32'h1234_5678);
      do_reset("d");
      run_instr("d_addi", 3);
      @(negedge ft_clk);
      @(negedge ft_clk);
      chk("d_ld_rstrb", {31'h0, bus_if.mem_rstrb}, 32'h1);
      chk("d_ld_addr", bus_if.mem_addr, 32'h0000_0040);
      @(negedge ft_clk);
      chk("d_waitmem_done", {31'h0, bus_if.inst_done}, 32'h1);
      resetn = 1'b0;
      #1;
      chk("d_abort_done", {31'h0, bus_if.inst_done}, 32'h0);
      chk("d_abort_rstrb", {31'h0, bus_if.mem_rstrb}, 32'h0);
      @(negedge ft_clk);
      chk("d_abort_x6", dut.RegisterBank[6], 32'h0000_0055);
      chk("d_abort_pc", dut.PC, 32'h0000_0000);
      resetn = 1'b1;
      #1;
      chk("d_refetch_start", {31'h0, bus_if.inst_start}, 32'h1);
      chk("d_refetch_addr", bus_if.mem_addr, 32'h0000_0000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
